mem_ctrl: RTL and testbench

- Byte-serial memory controller and arbiter for the single 8-bit synchronous RAM port.
- Shares the port between instruction fetch (IF, always 4 bytes) and the MEM stage's load/save requests, which carry an address, a length of 1/2/4 bytes and a signedness flag.
- Sequences the RAM one byte per cycle, assembles little-endian words and sign/zero-extends loads.
- Returns a one-cycle ready pulse to the owning requester.

---
 rtl/mem_ctrl_pkg.sv | 36 +++
 rtl/mem_ctrl_ext.sv | 29 ++
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared types and constants for the byte-serial memory controller.
//   - state_t : controller sequencing states
//   - owner_t : which requester owns the current transaction
//   - LEN_*   : byte counts of a transaction
//   - norm_len: maps the raw request length onto 1, 2 or 4 bytes
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // Any length other than byte or halfword is a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// ---------------------------------------------------------------------------
// mem_ctrl_ext
//   Combinational load extension: takes the little-endian assembled buffer
//   and produces the 32-bit register value for a byte, halfword or word load.
//   Ports:
//     raw  in  32  assembled read buffer (byte 0 in bits [7:0])
//     len  in   3  normalised length (LEN_B / LEN_H / LEN_W)
//     sgn  in   1  sign-extend when 1, zero-extend when 0
//     data out 32  extended load value
// ---------------------------------------------------------------------------
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  len,
    input  logic        sgn,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (len)
            LEN_B:   data = {{24{sgn & raw[7]}},  raw[7:0]};
            LEN_H:   data = {{16{sgn & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//   Byte-serial controller/arbiter for a single 8-bit synchronous RAM port,
//   shared between instruction fetch (4-byte reads) and load/save requests
//   of 1, 2 or 4 bytes. One RAM byte is moved per cycle; read bytes are
//   assembled little-endian, loads are sign/zero-extended, and the owning
//   requester gets a one-cycle ready pulse.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     if_req/if_addr/if_flush      fetch request, address, fetch abort
//     if_ready/if_inst             fetch completion pulse and instruction
//     mem_req/mem_wr/mem_addr      load/save request, direction, address
//     mem_wdata/mem_len/mem_signed save data, byte count, load signedness
//     mem_ready/mem_rdata          load/save completion pulse and load data
//     ram_addr/ram_wdata/ram_we    registered RAM address, write byte, enable
//     ram_rdata                    RAM read byte, valid one cycle after addr
// ---------------------------------------------------------------------------
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17   // must be below 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    input  logic                      if_flush,
    output logic                      if_ready,
    output logic [31:0]               if_inst,
    input  logic                      mem_req,
    input  logic                      mem_wr,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [2:0]                mem_len,
    input  logic                      mem_signed,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_wdata,
    output logic                      ram_we,
    input  logic [7:0]                ram_rdata
);

    state_t                    state;
    owner_t                    owner;
    logic [RAM_ADDR_WIDTH-1:0] base;
    logic [2:0]                len;
    logic [2:0]                step;
    logic [31:0]               wdata_q;
    logic                      sgn_q;
    logic [31:0]               rbuf;
    logic                      if_ready_q;

    logic [2:0]                step_inc;
    logic [1:0]                step_dec;
    logic [RAM_ADDR_WIDTH-1:0] addr_next;
    logic [7:0]                wbyte_next;
    logic [31:0]               rbuf_next;
    logic [31:0]               ext_data;

    // Address bits above the RAM width are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:RAM_ADDR_WIDTH], mem_addr[31:RAM_ADDR_WIDTH]};

    assign step_inc   = step + 3'd1;
    assign step_dec   = step[1:0] - 2'd1;
    // Address arithmetic wraps naturally at the RAM width.
    assign addr_next  = base + RAM_ADDR_WIDTH'(step_inc);
    assign wbyte_next = wdata_q[{step_inc[1:0], 3'b000} +: 8];

    // Read buffer including the byte arriving this cycle (byte step-1), so
    // the final byte can be folded into the result on the edge into DONE.
    always_comb begin
        rbuf_next = rbuf;
        if (step != 3'd0) begin
            rbuf_next[{step_dec, 3'b000} +: 8] = ram_rdata;
        end
    end

    mem_ctrl_ext u_ext (
        .raw  (rbuf_next),
        .len  (len),
        .sgn  (sgn_q),
        .data (ext_data)
    );

    // A flush arriving during the fetch DONE cycle must still suppress the
    // pulse, which is already registered, so the pulse is masked here.
    assign if_ready = if_ready_q & ~if_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            base       <= '0;
            len        <= '0;
            step       <= '0;
            wdata_q    <= '0;
            sgn_q      <= 1'b0;
            rbuf       <= '0;
            if_ready_q <= 1'b0;
            if_inst    <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            mem_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    step <= '0;
                    rbuf <= '0;
                    if (mem_req) begin
                        owner    <= OWN_MEM;
                        base     <= mem_addr[RAM_ADDR_WIDTH-1:0];
                        len      <= norm_len(mem_len);
                        wdata_q  <= mem_wdata;
                        sgn_q    <= mem_signed;
                        ram_addr <= mem_addr[RAM_ADDR_WIDTH-1:0];
                        if (mem_wr) begin
                            state     <= ST_WRITE;
                            ram_wdata <= mem_wdata[7:0];
                            ram_we    <= 1'b1;
                        end else begin
                            state <= ST_READ;
                        end
                    end else if (if_req && !if_flush) begin
                        owner    <= OWN_IF;
                        base     <= if_addr[RAM_ADDR_WIDTH-1:0];
                        len      <= LEN_W;
                        wdata_q  <= '0;
                        sgn_q    <= 1'b0;
                        ram_addr <= if_addr[RAM_ADDR_WIDTH-1:0];
                        state    <= ST_READ;
                    end
                end

                // Step s presents address base+s (s < len) and captures the
                // byte addressed in step s-1 (s >= 1); step len ends the read.
                ST_READ: begin
                    if (owner == OWN_IF && if_flush) begin
                        state <= ST_IDLE;
                    end else begin
                        rbuf <= rbuf_next;
                        if (step == len) begin
                            state <= ST_DONE;
                            if (owner == OWN_IF) begin
                                if_inst    <= rbuf_next;
                                if_ready_q <= 1'b1;
                            end else begin
                                mem_rdata <= ext_data;
                                mem_ready <= 1'b1;
                            end
                        end else begin
                            step <= step_inc;
                            if (step_inc != len) begin
                                ram_addr <= addr_next;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (step_inc == len) begin
                        ram_we    <= 1'b0;
                        mem_rdata <= '0;
                        mem_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        step      <= step_inc;
                        ram_addr  <= addr_next;
                        ram_wdata <= wbyte_next;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int AW  = 17;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, mem_req, mem_wr, mem_signed;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [2:0]    mem_len;
    logic          if_ready, mem_ready, ram_we;
    logic [31:0]   if_inst, mem_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;

    logic [7:0]    ram     [MSZ];   // RAM seen by the DUT
    logic [7:0]    ref_mem [MSZ];   // model's own view of memory

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_ready   (if_ready),
        .if_inst    (if_inst),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_len    (mem_len),
        .mem_signed (mem_signed),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    // ---------------- transaction-level reference model ----------------
    int            m_rdy  = -1;   // cycle of expected ready pulse
    int            m_free = 0;    // first cycle a new request may be accepted
    int            m_T, m_N;
    bit            m_own_if;
    logic [31:0]   m_data, m_inst, m_rdata;
    logic [AW-1:0] e_addr [int];  // expected ram_addr per cycle
    logic [7:0]    e_wd   [int];  // expected write byte per cycle (implies we)

    always @(negedge clk) begin : model
        int            c, n;
        logic [AW-1:0] a, aa;
        logic [31:0]   v;
        c = cyc;
        if (rst) begin
            chk("rst_if_ready", {31'd0, if_ready}, 0);
            chk("rst_mem_ready", {31'd0, mem_ready}, 0);
            chk("rst_ram_we", {31'd0, ram_we}, 0);
            chk("rst_if_inst", if_inst, 0);
            chk("rst_mem_rdata", mem_rdata, 0);
            chk("rst_ram_addr", 32'(ram_addr), 0);
            chk("rst_ram_wdata", 32'(ram_wdata), 0);
            e_addr.delete();
            e_wd.delete();
            m_rdy = -1; m_free = 0; m_inst = '0; m_rdata = '0;
        end else begin
            if (c == m_rdy) begin
                if (m_own_if) m_inst = m_data;
                else          m_rdata = m_data;
            end
            chk("if_ready", {31'd0, if_ready}, {31'd0, (m_own_if && c == m_rdy && !if_flush)});
            chk("mem_ready", {31'd0, mem_ready}, {31'd0, (!m_own_if && c == m_rdy)});
            chk("if_inst", if_inst, m_inst);
            chk("mem_rdata", mem_rdata, m_rdata);
            chk("ram_we", {31'd0, ram_we}, {31'd0, e_wd.exists(c)});
            if (e_addr.exists(c)) begin
                chk("ram_addr", 32'(ram_addr), 32'(e_addr[c]));
                if (e_wd.exists(c)) begin
                    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd[c]));
                    ref_mem[e_addr[c]] = e_wd[c];
                    e_wd.delete(c);
                end
                e_addr.delete(c);
            end
            // flush aborts a fetch still collecting bytes
            if (m_own_if && m_rdy >= 0 && if_flush && c > m_T && c <= m_T + m_N + 1) begin
                for (int k = c + 1; k <= c + 8; k++) begin
                    if (e_addr.exists(k)) e_addr.delete(k);
                end
                m_rdy  = -1;
                m_free = c + 1;
            end
            if (c >= m_free) begin
                if (mem_req) begin
                    n = (mem_len == 3'd1) ? 1 : (mem_len == 3'd2) ? 2 : 4;
                    a = mem_addr[AW-1:0];
                    m_T = c; m_N = n; m_own_if = 1'b0;
                    v = '0;
                    for (int s = 0; s < n; s++) begin
                        aa = a + AW'(s);
                        e_addr[c + 1 + s] = aa;
                        if (mem_wr) e_wd[c + 1 + s] = mem_wdata[8*s +: 8];
                        else        v[8*s +: 8] = ref_mem[aa];
                    end
                    if (mem_wr) begin
                        m_data = '0; m_rdy = c + n + 1; m_free = c + n + 2;
                    end else begin
                        if (n == 1 && mem_signed && v[7])  v = v | 32'hFFFF_FF00;
                        if (n == 2 && mem_signed && v[15]) v = v | 32'hFFFF_0000;
                        m_data = v; m_rdy = c + n + 2; m_free = c + n + 3;
                    end
                end else if (if_req && !if_flush) begin
                    a = if_addr[AW-1:0];
                    m_T = c; m_N = 4; m_own_if = 1'b1;
                    v = '0;
                    for (int s = 0; s < 4; s++) begin
                        aa = a + AW'(s);
                        e_addr[c + 1 + s] = aa;
                        v[8*s +: 8] = ref_mem[aa];
                    end
                    m_data = v; m_rdy = c + 6; m_free = c + 7;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [AW-1:0] addr_log [32];
    logic          we_log   [32];
    logic [7:0]    wd_log   [32];
    logic [31:0]   ifr_data, memr_data;

    // Starts in the cycle the request was driven; records the cycle offset of
    // each ready pulse and drops the matching request the following cycle.
    task automatic watch(input int span, output int ifr_at, output int memr_at);
        int t0;
        bit drop_if, drop_mem;
        t0 = cyc; ifr_at = -1; memr_at = -1; drop_if = 0; drop_mem = 0;
        for (int k = 0; k <= span; k++) begin
            if (k > 0) begin
                step_in();
                if (drop_if)  if_req  = 1'b0;
                if (drop_mem) mem_req = 1'b0;
            end
            @(negedge clk);
            addr_log[k] = ram_addr;
            we_log[k]   = ram_we;
            wd_log[k]   = ram_wdata;
            if (if_ready && ifr_at < 0) begin
                ifr_at = cyc - t0; ifr_data = if_inst; drop_if = 1;
            end
            if (mem_ready && memr_at < 0) begin
                memr_at = cyc - t0; memr_data = mem_rdata; drop_mem = 1;
            end
        end
        step_in();
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 6)      r[16:0] = 17'($urandom_range(0, 63));
        else if (sel < 8) r[16:0] = 17'h1FFFC + 17'($urandom_range(0, 3));
        else              r[16:0] = 17'($urandom_range(256, 271));
        return r;
    endfunction

    task automatic fetch_agent(input int n);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit done, got, fl;
            if_req = 1'b1; if_addr = rand_addr();
            waited = 0; done = 0; got = 0; fl = 0;
            while (!done) begin
                if_flush = ($urandom_range(0, 39) == 0);
                @(negedge clk);
                if (if_ready) got = 1;
                if (if_flush) fl = 1;
                waited++;
                if (got || fl || waited > 300) done = 1;
                step_in();
            end
            chk("fetch_handshake", {31'd0, (got || fl)}, 1);
            if_req = 1'b0; if_flush = 1'b0;
            repeat ($urandom_range(0, 2)) step_in();
        end
    endtask

    task automatic mem_agent(input int n);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit got;
            mem_req = 1'b1; mem_wr = 1'($urandom_range(0, 1)); mem_addr = rand_addr();
            mem_wdata = $urandom; mem_len = 3'($urandom_range(0, 7));
            mem_signed = 1'($urandom_range(0, 1));
            waited = 0; got = 0;
            while (!got && waited <= 300) begin
                @(negedge clk);
                if (mem_ready) got = 1;
                waited++;
                step_in();
            end
            chk("mem_handshake", {31'd0, got}, 1);
            mem_req = 1'b0;
            repeat ($urandom_range(0, 2)) step_in();
        end
    endtask

    initial begin : watchdog
        #600000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ifr, memr, t0;
        bit seen;
        logic [7:0] b;
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; mem_len = 0; mem_signed = 0;
        for (int i = 0; i < MSZ; i++) begin
            b = 8'($urandom);
            ram[i] = b; ref_mem[i] = b;
        end
        poke('h100, 8'h13); poke('h101, 8'h05); poke('h102, 8'hA0); poke('h103, 8'h00);
        poke('h20, 8'h80);
        poke('h40, 8'h11); poke('h41, 8'h22); poke('h42, 8'h5A);
        poke('h10, 8'h78); poke('h11, 8'h56); poke('h12, 8'h34); poke('h13, 8'h12);
        poke('h300, 8'hEF); poke('h301, 8'hBE); poke('h302, 8'hAD); poke('h303, 8'hDE);
        poke('h50, 8'h11); poke('h51, 8'h22); poke('h52, 8'h33); poke('h53, 8'h44);
        repeat (3) step_in();
        chk("reset_if_inst", if_inst, 0);
        chk("reset_ram_we", {31'd0, ram_we}, 0);
        rst = 1'b0;

        // fetch
        if_req = 1; if_addr = 32'h0000_0100;
        watch(8, ifr, memr);
        chk("fetch_ready_at", ifr, 6);
        for (int k = 1; k <= 4; k++) chk("fetch_addr", 32'(addr_log[k]), 32'h100 + k - 1);
        chk("fetch_inst", ifr_data, 32'h00A0_0513);

        // signed / unsigned byte load
        mem_req = 1; mem_wr = 0; mem_addr = 32'h0000_0020; mem_len = 3'd1; mem_signed = 1;
        watch(5, ifr, memr);
        chk("lb_ready_at", memr, 3);
        chk("lb_data", memr_data, 32'hFFFF_FF80);
        mem_req = 1; mem_wr = 0; mem_addr = 32'h0000_0020; mem_len = 3'd1; mem_signed = 0;
        watch(5, ifr, memr);
        chk("lbu_data", memr_data, 32'h0000_0080);

        // halfword save
        mem_req = 1; mem_wr = 1; mem_addr = 32'h0000_0040; mem_wdata = 32'h1234_ABCD; mem_len = 3'd2;
        watch(5, ifr, memr);
        chk("sh_ready_at", memr, 3);
        chk("sh_we1", {31'd0, we_log[1]}, 1);
        chk("sh_addr1", 32'(addr_log[1]), 32'h40);
        chk("sh_byte1", 32'(wd_log[1]), 32'hCD);
        chk("sh_addr2", 32'(addr_log[2]), 32'h41);
        chk("sh_byte2", 32'(wd_log[2]), 32'hAB);
        chk("sh_we_done", {31'd0, we_log[3]}, 0);
        chk("sh_rdata", memr_data, 0);
        chk("sh_ram42", 32'(ram['h42]), 32'h5A);
        chk("sh_ram40", 32'(ram['h40]), 32'hCD);

        // contention: load wins, fetch follows
        if_req = 1; if_addr = 32'h0000_0100;
        mem_req = 1; mem_wr = 0; mem_addr = 32'h0000_0010; mem_len = 3'd4; mem_signed = 0;
        watch(15, ifr, memr);
        chk("cont_mem_at", memr, 6);
        chk("cont_mem_data", memr_data, 32'h1234_5678);
        chk("cont_if_at", ifr, 13);
        chk("cont_if_inst", ifr_data, 32'h00A0_0513);

        // flush of an ongoing fetch, then refetch
        if_req = 1; if_addr = 32'h0000_0200; seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step_in();
            if (k == 3) if_flush = 1;
            @(negedge clk);
            if (if_ready) seen = 1;
        end
        step_in();
        if_flush = 0; if_addr = 32'h0000_0300;
        watch(8, ifr, memr);
        chk("flush_no_ready", {31'd0, seen}, 0);
        chk("refetch_addr", 32'(addr_log[1]), 32'h300);
        chk("refetch_at", ifr, 6);
        chk("refetch_inst", ifr_data, 32'hDEAD_BEEF);

        // reset during write step 1
        mem_req = 1; mem_wr = 1; mem_addr = 32'h0000_0050; mem_wdata = 32'hA5A5_A5A5; mem_len = 3'd4;
        step_in();
        step_in();
        rst = 1'b1;
        #1;
        chk("rst_we_drop", {31'd0, ram_we}, 0);
        chk("rst_mem_ready_now", {31'd0, mem_ready}, 0);
        mem_req = 0;
        step_in();
        step_in();
        rst = 1'b0;
        mem_req = 1; mem_wr = 0; mem_addr = 32'h0000_0050; mem_len = 3'd4; mem_signed = 1;
        watch(8, ifr, memr);
        chk("post_rst_lw_at", memr, 6);
        chk("post_rst_lw", memr_data, 32'h4433_22A5);

        // randomized traffic against the model
        fork
            fetch_agent(120);
            mem_agent(150);
        join
        repeat (5) step_in();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
